// File: rtl/sync_fifo_sa_if.sv
// Purpose: write/read request and status bundle for sync_fifo_sa.
// Latency: none; plain wires between producer/consumer and the FIFO.
// Backpressure: full_o/empty_o tell the master when requests will be dropped.
interface sync_fifo_sa_if #(
  parameter int DWIDTH = 8,
  parameter int AWIDTH = 4
);
  logic [DWIDTH-1:0] data_i;
  logic              wrreq_i;
  logic              rdreq_i;
  logic [DWIDTH-1:0] q_o;
  logic              empty_o;
  logic              full_o;
  logic [AWIDTH:0]   usedw_o;
  logic              almost_full_o;
  logic              almost_empty_o;

  modport master (
    output data_i, wrreq_i, rdreq_i,
    input  q_o, empty_o, full_o, usedw_o, almost_full_o, almost_empty_o
  );

  modport slave (
    input  data_i, wrreq_i, rdreq_i,
    output q_o, empty_o, full_o, usedw_o, almost_full_o, almost_empty_o
  );
endinterface

// File: rtl/sync_fifo_sa.sv
// Purpose: single-clock FIFO on an inferred block RAM, normal or show-ahead read.
// Latency: normal q_o valid one edge after the accepting edge; show-ahead head visible two edges after a write into empty.
// Backpressure: writes while full_o and reads while empty_o are dropped with no state change.
module sync_fifo_sa #(
  parameter int DWIDTH       = 8,
  parameter int AWIDTH       = 4,
  parameter int SHOWAHEAD    = 0,
  parameter int ALMOST_FULL  = 2**AWIDTH-2,
  parameter int ALMOST_EMPTY = 2
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic          srst_i,
  sync_fifo_sa_if.slave fifo
);

  localparam int                DEPTH   = 2**AWIDTH;
  localparam logic [AWIDTH:0]   DEPTH_W = (AWIDTH+1)'(DEPTH);
  localparam logic [AWIDTH:0]   AF_LVL  = (AWIDTH+1)'(ALMOST_FULL);
  localparam logic [AWIDTH:0]   AE_LVL  = (AWIDTH+1)'(ALMOST_EMPTY);
  localparam logic [AWIDTH:0]   ONE_W   = (AWIDTH+1)'(1);
  localparam logic [AWIDTH-1:0] ONE_P   = AWIDTH'(1);

  logic [DWIDTH-1:0] mem [DEPTH];

  logic [AWIDTH-1:0] wr_ptr;
  logic [AWIDTH-1:0] rd_ptr;
  logic [AWIDTH:0]   usedw;
  logic [AWIDTH:0]   usedw_nxt;
  logic              full_r;
  logic              af_r;
  logic              ae_r;
  logic              wr_acc;
  logic              rd_acc;
  logic              rd_adv;     // RAM read pointer moves on (mode dependent)
  logic              empty_w;
  logic [DWIDTH-1:0] q_w;

  assign wr_acc = fifo.wrreq_i && !full_r;
  assign rd_acc = fifo.rdreq_i && !empty_w;

  assign fifo.q_o            = q_w;
  assign fifo.empty_o        = empty_w;
  assign fifo.full_o         = full_r;
  assign fifo.usedw_o        = usedw;
  assign fifo.almost_full_o  = af_r;
  assign fifo.almost_empty_o = ae_r;

  // Next fill level: a simultaneous accepted read and write cancel out.
  always_comb begin
    usedw_nxt = usedw;
    if (wr_acc && !rd_acc) begin
      usedw_nxt = usedw + ONE_W;
    end else if (rd_acc && !wr_acc) begin
      usedw_nxt = usedw - ONE_W;
    end
  end

  // Pointers, fill count and registered level flags.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      usedw  <= '0;
      full_r <= 1'b0;
      af_r   <= 1'b0;
      ae_r   <= 1'b1;
    end else if (srst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      usedw  <= '0;
      full_r <= 1'b0;
      af_r   <= 1'b0;
      ae_r   <= 1'b1;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + ONE_P;
      if (rd_adv) rd_ptr <= rd_ptr + ONE_P;
      usedw  <= usedw_nxt;
      full_r <= (usedw_nxt == DEPTH_W);
      af_r   <= (usedw_nxt >= AF_LVL);
      ae_r   <= (usedw_nxt <  AE_LVL);
    end
  end

  // RAM write port; a write coinciding with reset or clear is dropped.
  always_ff @(posedge clk_i) begin
    if (wr_acc && rst_n_i && !srst_i) begin
      mem[wr_ptr] <= fifo.data_i;
    end
  end

  if (SHOWAHEAD != 0) begin : g_sa
    // ram stage: prefetched word behind the head; out stage: the visible head.
    logic [DWIDTH-1:0] ram_q;
    logic [DWIDTH-1:0] out_q;
    logic              ram_vld;
    logic              out_vld;
    logic [AWIDTH:0]   mem_cnt;
    logic              ram_to_out;
    logic              ram_free;
    logic              fetch_mem;
    logic              fetch_byp;
    logic              out_byp;

    // Words still only in the RAM array, not yet pulled into either stage.
    assign mem_cnt    = usedw - {{AWIDTH{1'b0}}, ram_vld} - {{AWIDTH{1'b0}}, out_vld};
    assign ram_to_out = ram_vld && (rd_acc || !out_vld);
    assign ram_free   = !ram_vld || ram_to_out;
    // Only word left is being read while another arrives: hand it straight to the head.
    assign out_byp    = rd_acc && !ram_vld && (mem_cnt == '0) && wr_acc;
    assign fetch_mem  = ram_free && (mem_cnt != '0);
    // Once the head is (becoming) visible, a write with nothing queued in RAM skips the
    // RAM latency so the prefetch slot stays full; a write into an empty FIFO does not.
    assign fetch_byp  = ram_free && (mem_cnt == '0) && wr_acc &&
                        (out_vld || ram_to_out) && !out_byp;
    assign rd_adv     = fetch_mem || fetch_byp || out_byp;
    assign empty_w    = !out_vld;
    assign q_w        = out_q;

    // Prefetch register (registered RAM read) and head holding register.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
        ram_q   <= '0;
        ram_vld <= 1'b0;
        out_q   <= '0;
        out_vld <= 1'b0;
      end else if (srst_i) begin
        ram_q   <= '0;
        ram_vld <= 1'b0;
        out_q   <= '0;
        out_vld <= 1'b0;
      end else begin
        if (fetch_mem) begin
          ram_q   <= mem[rd_ptr];
          ram_vld <= 1'b1;
        end else if (fetch_byp) begin
          ram_q   <= fifo.data_i;
          ram_vld <= 1'b1;
        end else if (ram_to_out) begin
          ram_vld <= 1'b0;
        end

        if (out_byp) begin
          out_q   <= fifo.data_i;
          out_vld <= 1'b1;
        end else if (!out_vld || rd_acc) begin
          out_vld <= ram_vld;
          if (ram_vld) out_q <= ram_q;
        end
      end
    end
  end else begin : g_norm
    logic [DWIDTH-1:0] ram_q;
    logic [DWIDTH-1:0] out_q;
    logic              rd_d;
    logic              empty_r;

    assign rd_adv  = rd_acc;
    assign empty_w = empty_r;
    assign q_w     = out_q;

    // Registered RAM read, then output register that holds until the next read.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
        ram_q   <= '0;
        out_q   <= '0;
        rd_d    <= 1'b0;
        empty_r <= 1'b1;
      end else if (srst_i) begin
        ram_q   <= '0;
        out_q   <= '0;
        rd_d    <= 1'b0;
        empty_r <= 1'b1;
      end else begin
        if (rd_acc) ram_q <= mem[rd_ptr];
        rd_d    <= rd_acc;
        if (rd_d) out_q <= ram_q;
        empty_r <= (usedw_nxt == '0);
      end
    end
  end

endmodule

// File: tb/tb_sync_fifo_sa.sv
// Purpose: drive a normal-mode and a show-ahead instance side by side against queue models.
// Latency: inputs change 1 time unit after the rising edge, outputs checked at the same point.
// Backpressure: models decide acceptance from their own occupancy and visibility.
module tb_sync_fifo_sa;
  logic clk = 1'b0;
  logic rst_n;
  logic srst;

  always #5 clk = ~clk;

  sync_fifo_sa_if #(.DWIDTH(8), .AWIDTH(4)) if0 ();
  sync_fifo_sa_if #(.DWIDTH(8), .AWIDTH(4)) if1 ();

  sync_fifo_sa #(.DWIDTH(8), .AWIDTH(4), .SHOWAHEAD(0), .ALMOST_FULL(14), .ALMOST_EMPTY(2))
    dut_n (.clk_i(clk), .rst_n_i(rst_n), .srst_i(srst), .fifo(if0));
  sync_fifo_sa #(.DWIDTH(8), .AWIDTH(4), .SHOWAHEAD(1), .ALMOST_FULL(14), .ALMOST_EMPTY(2))
    dut_s (.clk_i(clk), .rst_n_i(rst_n), .srst_i(srst), .fifo(if1));

  int n_cmp = 0;
  int n_bad = 0;

  // Normal-mode model: stored words, plus the word popped last edge that lands on q next edge.
  logic [7:0] nq[$];
  logic [7:0] n_exp_q;
  logic [7:0] n_pend;
  bit         n_pend_vld;

  // Show-ahead model: stored words, head visibility and the two-edge reveal countdown.
  logic [7:0] sq[$];
  bit         s_vis;
  int         s_cd;
  logic [7:0] s_last;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic models_clear();
    nq.delete();
    n_exp_q    = 8'h00;
    n_pend     = 8'h00;
    n_pend_vld = 1'b0;
    sq.delete();
    s_vis  = 1'b0;
    s_cd   = 0;
    s_last = 8'h00;
  endtask

  task automatic check_all();
    chk("n_usedw",  32'(if0.usedw_o),        32'(nq.size()));
    chk("n_full",   32'(if0.full_o),         32'(nq.size() == 16));
    chk("n_empty",  32'(if0.empty_o),        32'(nq.size() == 0));
    chk("n_afull",  32'(if0.almost_full_o),  32'(nq.size() >= 14));
    chk("n_aempty", 32'(if0.almost_empty_o), 32'(nq.size() < 2));
    chk("n_q",      32'(if0.q_o),            32'(n_exp_q));
    chk("s_usedw",  32'(if1.usedw_o),        32'(sq.size()));
    chk("s_full",   32'(if1.full_o),         32'(sq.size() == 16));
    chk("s_empty",  32'(if1.empty_o),        32'(!s_vis));
    chk("s_afull",  32'(if1.almost_full_o),  32'(sq.size() >= 14));
    chk("s_aempty", 32'(if1.almost_empty_o), 32'(sq.size() < 2));
    chk("s_q",      32'(if1.q_o),            32'(s_last));
  endtask

  // One clock: decide acceptance from the models, take the edge, update models, check.
  task automatic step();
    bit         nw, nr, sw, sr, s_was_empty, clr;
    logic [7:0] d0, d1;
    nw  = if0.wrreq_i && (nq.size() < 16);
    nr  = if0.rdreq_i && (nq.size() > 0);
    sw  = if1.wrreq_i && (sq.size() < 16);
    sr  = if1.rdreq_i && s_vis;
    d0  = if0.data_i;
    d1  = if1.data_i;
    clr = srst;
    @(posedge clk);
    #1;
    if (clr) begin
      models_clear();
    end else begin
      if (n_pend_vld) n_exp_q = n_pend;
      n_pend_vld = nr;
      if (nr) n_pend = nq.pop_front();
      if (nw) nq.push_back(d0);

      s_was_empty = (sq.size() == 0);
      if (sr) void'(sq.pop_front());
      if (sw) sq.push_back(d1);
      if (s_cd > 0) begin
        s_cd--;
        if (s_cd == 0) s_vis = 1'b1;
      end else if (!s_vis && s_was_empty && sw) begin
        s_cd = 2;
      end
      if (s_vis && sq.size() == 0) s_vis = 1'b0;
      if (s_vis) s_last = sq[0];
    end
    check_all();
  endtask

  task automatic drive(input logic w0, input logic [7:0] d0, input logic r0,
                       input logic w1, input logic [7:0] d1, input logic r1);
    if0.wrreq_i = w0;
    if0.data_i  = d0;
    if0.rdreq_i = r0;
    if1.wrreq_i = w1;
    if1.data_i  = d1;
    if1.rdreq_i = r1;
    step();
  endtask

  initial begin
    rst_n = 1'b0;
    srst  = 1'b0;
    if0.wrreq_i = 1'b0; if0.rdreq_i = 1'b0; if0.data_i = 8'h00;
    if1.wrreq_i = 1'b0; if1.rdreq_i = 1'b0; if1.data_i = 8'h00;
    models_clear();
    #12;
    check_all();
    rst_n = 1'b1;

    // Normal mode: fill 16, rejected 17th write, drain 17 reads.
    for (int i = 0; i < 16; i++) drive(1'b1, 8'(i), 1'b0, 1'b0, 8'h00, 1'b0);
    drive(1'b1, 8'hAA, 1'b0, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 17; i++) drive(1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0);
    drive(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
    drive(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);

    // Wrap-around: 10 in/out, then 12 in/out across the pointer wrap.
    for (int i = 0; i < 10; i++) drive(1'b1, 8'(i), 1'b0, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 10; i++) drive(1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 12; i++) drive(1'b1, 8'(i), 1'b0, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 13; i++) drive(1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0);

    // Simultaneous read+write at occupancy 5 for 20 cycles.
    for (int i = 0; i < 5; i++) drive(1'b1, 8'(8'h40 + i), 1'b0, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 20; i++) drive(1'b1, 8'($urandom), 1'b1, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 7; i++) drive(1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0);

    // Show-ahead: single write, then continuous writes with reads held high.
    drive(1'b0, 8'h00, 1'b0, 1'b1, 8'h5C, 1'b0);
    for (int i = 1; i <= 8; i++) drive(1'b0, 8'h00, 1'b0, 1'b1, 8'(i), 1'b1);
    for (int i = 0; i < 8; i++) drive(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1);

    // Show-ahead: sustained read+write with a single visible word.
    drive(1'b0, 8'h00, 1'b0, 1'b1, 8'h90, 1'b0);
    for (int i = 0; i < 3; i++) drive(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 10; i++) drive(1'b0, 8'h00, 1'b0, 1'b1, 8'(8'hA0 + i), 1'b1);
    for (int i = 0; i < 3; i++) drive(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1);

    // Show-ahead fill to full with a rejected extra write.
    for (int i = 0; i < 17; i++) drive(1'b0, 8'h00, 1'b0, 1'b1, 8'(8'hC0 + i), 1'b0);

    // Synchronous clear at occupancy 7 with concurrent requests.
    srst = 1'b1;
    drive(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
    srst = 1'b0;
    for (int i = 0; i < 7; i++) drive(1'b1, 8'(8'h70 + i), 1'b0, 1'b1, 8'(8'h70 + i), 1'b0);
    for (int i = 0; i < 3; i++) drive(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
    srst = 1'b1;
    drive(1'b1, 8'hEE, 1'b1, 1'b1, 8'hEE, 1'b1);
    srst = 1'b0;
    for (int i = 0; i < 3; i++) drive(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);

    // Randomized traffic, fill-biased then drain-biased, with rare clears.
    for (int i = 0; i < 600; i++) begin
      bit bias;
      bias = (i % 200) < 100;
      srst = ($urandom_range(0, 149) == 0);
      drive(1'($urandom_range(0, 99) < (bias ? 75 : 30)), 8'($urandom),
            1'($urandom_range(0, 99) < (bias ? 30 : 75)),
            1'($urandom_range(0, 99) < (bias ? 75 : 30)), 8'($urandom),
            1'($urandom_range(0, 99) < (bias ? 30 : 75)));
    end
    srst = 1'b0;

    // Asynchronous reset pulse mid-cycle with data stored: outputs clear at once.
    for (int i = 0; i < 6; i++) drive(1'b1, 8'(8'h30 + i), 1'b0, 1'b1, 8'(8'h30 + i), 1'b0);
    for (int i = 0; i < 3; i++) drive(1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1);
    drive(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    models_clear();
    check_all();
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) drive(1'b1, 8'(8'h11 * i), 1'b0, 1'b1, 8'(8'h11 * i), 1'b0);
    for (int i = 0; i < 6; i++) drive(1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/sync_fifo_sa.md
Name: sync_fifo_sa

Overview:
- Parametrised single-clock FIFO built around an inferred block-RAM array with a synchronous, registered read port.
- Adds the following to the plain RAM primitive:
  - read and write pointer management;
  - full/empty, almost-full/almost-empty and fill-count flags;
  - overflow/underflow protection;
  - a selectable show-ahead (first-word-fall-through) or normal read mode.
- Used as the standard buffering stage between streaming blocks in the lab designs.

Parameters:
- DWIDTH, 8: data word width in bits.
- AWIDTH, 4: address width; depth = 2**AWIDTH words.
- SHOWAHEAD, 0: 0 = normal mode, 1 = show-ahead mode.
- ALMOST_FULL, 2**AWIDTH-2: almost_full_o threshold, in words.
- ALMOST_EMPTY, 2: almost_empty_o threshold, in words.

Ports:
- clk_i  in  1  clock; all logic on the rising edge.
- rst_n_i  in  1  asynchronous reset, active-low.
- srst_i  in  1  synchronous clear, active-high; same effect as reset.
- data_i  in  DWIDTH  write data.
- wrreq_i  in  1  write request.
- rdreq_i  in  1  read request (normal mode) / acknowledge of the head word (show-ahead mode).
- q_o  out  DWIDTH  read data.
- empty_o  out  1  no readable word.
- full_o  out  1  2**AWIDTH words stored.
- usedw_o  out  AWIDTH+1  number of stored words.
- almost_full_o  out  1  usedw_o >= ALMOST_FULL.
- almost_empty_o  out  1  usedw_o < ALMOST_EMPTY.

Behaviour:
- Reset and clear:
  - rst_n_i low (async) or srst_i high (sync) sets: pointers = 0, usedw_o = 0, empty_o = 1, full_o = 0, almost_empty_o = 1, almost_full_o = 0, q_o = 0.
  - Memory contents are not cleared.
  - Reset asserted mid-transfer aborts the transfer immediately; no partial word survives.
- Request acceptance:
  - Write accepted iff wrreq_i && !full_o.
  - Read accepted iff rdreq_i && !empty_o.
  - Rejected requests cause no state change. This includes a write while full, even with a simultaneous read.
- Pointer and count rules:
  - Pointers are AWIDTH bits and wrap from 2**AWIDTH-1 to 0.
  - usedw_o, full_o and the almost flags are registered and update on the edge after the accepted request.
  - Write only: usedw +1. Read only: usedw -1. Both accepted: usedw unchanged, and both pointers advance.
  - full_o = (usedw_o == 2**AWIDTH).
- Memory: write port is synchronous. Read port is registered inside the RAM (M10K-compatible, no read-during-write check required).
- Normal mode (SHOWAHEAD=0):
  - Read accepted at edge N: q_o holds the head word after edge N+1, i.e. one cycle read latency.
  - q_o holds its value until the next accepted read.
  - empty_o = (usedw_o == 0), with the same timing as usedw_o.
- Show-ahead mode (SHOWAHEAD=1):
  - q_o always presents the head word while empty_o = 0.
  - An output holding register plus a one-word prefetch hide the RAM latency.
  - Write into an empty FIFO at edge N: empty_o deasserts and q_o is valid after edge N+2. usedw_o = 1 after edge N, so usedw_o may be non-zero while empty_o = 1 for up to 2 cycles.
  - Read accepted at edge N with further words stored: the next word appears on q_o after edge N, with no bubble.
  - Sustained simultaneous read+write at any occupancy >= 1 visible word gives 1 word per cycle throughput.
  - Read of the last word: empty_o = 1 after that edge; q_o is undefined-but-stable (holds last value).
- Boundary conditions:
  - Write while full: ignored.
  - Read while empty: ignored.
  - Simultaneous read and write while empty: only the write is accepted. In show-ahead mode this holds until empty_o deasserts.

Test Plan:
- Reset, normal mode (DWIDTH=8, AWIDTH=4): pulse rst_n_i low asynchronously mid-cycle -> empty_o=1, full_o=0, usedw_o=0, q_o=0 immediately, without waiting for a clock edge.
- Fill and drain, normal mode:
  - Write 16 words 0x00..0x0F, then attempt a 17th write (0xAA) -> full_o=1, usedw_o=16, almost_full_o=1 from usedw_o=14; 0xAA is discarded.
  - Read 16 -> q_o 0x00..0x0F, each valid 1 cycle after its rdreq.
  - 17th read is ignored; empty_o=1.
- Wrap-around: write 10, read 10, write 12, read 12 -> data in order 0x00..0x0B with no corruption across the pointer wrap; usedw_o returns to 0.
- Simultaneous read+write at usedw_o=5 for 20 cycles -> usedw_o stays 5; output sequence matches input order.
- Show-ahead mode:
  - Single write of 0x5C into an empty FIFO -> empty_o=0 and q_o=0x5C two cycles later.
  - Then continuous write of 0x01..0x08 with rdreq_i held high whenever empty_o=0 -> back-to-back q_o 0x5C, 0x01..0x08 with no bubbles.
- srst_i asserted at usedw_o=7 together with wrreq_i=1 and rdreq_i=1 -> after the edge, usedw_o=0 and empty_o=1; the concurrent write is not retained.
